// File: rtl/pacman_move_sequencer.sv
// Pac-Man movement sequencer: buffers joystick requests, paces move attempts with a tick
// divider, checks each candidate tile over a wall-lookup handshake and commits legal moves.
module pacman_move_sequencer #(
  parameter int TICK_DIV = 10000,
  parameter int STEP     = 1,
  parameter int X_MIN    = 273,
  parameter int X_MAX    = 663,
  parameter int Y_MIN    = 58,
  parameter int Y_MAX    = 490,
  parameter int X_INI    = 300,
  parameter int Y_INI    = 300
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       ack,
  input  logic       win,
  input  logic       lose,
  input  logic       btn_l,
  input  logic       btn_u,
  input  logic       btn_r,
  input  logic       btn_d,
  output logic       wall_req,
  output logic [9:0] wall_x,
  output logic [9:0] wall_y,
  input  logic       wall_ack,
  input  logic       wall_blocked,
  output logic [9:0] pac_x,
  output logic [9:0] pac_y,
  output logic [2:0] dir_cur,
  output logic       move_pulse,
  output logic [1:0] halt_code
);

  localparam int CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

  localparam logic [2:0] DIR_NONE = 3'd0;
  localparam logic [2:0] DIR_L    = 3'd1;
  localparam logic [2:0] DIR_U    = 3'd2;
  localparam logic [2:0] DIR_R    = 3'd3;
  localparam logic [2:0] DIR_D    = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_TICK, S_LOOK_REQ, S_LOOK_CUR, S_COMMIT, S_HALT
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [9:0]       pac_x_q, pac_x_d, pac_y_q, pac_y_d;
  logic [9:0]       cand_x_q, cand_x_d, cand_y_q, cand_y_d;
  logic [2:0]       dir_cur_q, dir_cur_d, dir_req_q, dir_req_d, look_dir_q, look_dir_d;
  logic             wall_req_q, wall_req_d, move_pulse_q, move_pulse_d;
  logic [1:0]       halt_code_q, halt_code_d;

  logic [2:0] sel_dir;
  logic [9:0] sel_x, sel_y;
  logic       sel_stuck;

  // One STEP along the axis of dir, clamped into the playfield.
  function automatic logic [19:0] step_pos(input logic [2:0] dir, input logic [9:0] x,
                                           input logic [9:0] y);
    int nx, ny;
    nx = int'(x);
    ny = int'(y);
    case (dir)
      DIR_L:   nx = nx - STEP;
      DIR_R:   nx = nx + STEP;
      DIR_U:   ny = ny - STEP;
      DIR_D:   ny = ny + STEP;
      default: ;
    endcase
    if (nx < X_MIN) nx = X_MIN;
    if (nx > X_MAX) nx = X_MAX;
    if (ny < Y_MIN) ny = Y_MIN;
    if (ny > Y_MAX) ny = Y_MAX;
    return {10'(nx), 10'(ny)};
  endfunction

  assign sel_dir           = (state_q == S_LOOK_REQ) ? dir_req_q : dir_cur_q;
  assign {sel_x, sel_y}    = step_pos(sel_dir, pac_x_q, pac_y_q);
  assign sel_stuck         = (sel_x == pac_x_q) && (sel_y == pac_y_q);

  always_comb begin
    // NOTE: every _d gets its hold value first, so no path through the case can infer a latch.
    state_d      = state_q;
    cnt_d        = cnt_q;
    pac_x_d      = pac_x_q;
    pac_y_d      = pac_y_q;
    cand_x_d     = cand_x_q;
    cand_y_d     = cand_y_q;
    dir_cur_d    = dir_cur_q;
    dir_req_d    = dir_req_q;
    look_dir_d   = look_dir_q;
    wall_req_d   = wall_req_q;
    move_pulse_d = 1'b0;
    halt_code_d  = halt_code_q;

    case ({btn_l, btn_u, btn_r, btn_d})
      4'b1000: dir_req_d = DIR_L;
      4'b0100: dir_req_d = DIR_U;
      4'b0010: dir_req_d = DIR_R;
      4'b0001: dir_req_d = DIR_D;
      default: ;
    endcase

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_WAIT_TICK;
          cnt_d   = '0;
        end
      end
      S_WAIT_TICK: begin
        if (cnt_q == CNT_W'(TICK_DIV - 1)) begin
          cnt_d = '0;
          if (dir_req_q != DIR_NONE && dir_req_q != dir_cur_q) state_d = S_LOOK_REQ;
          else if (dir_cur_q != DIR_NONE)                      state_d = S_LOOK_CUR;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_LOOK_REQ, S_LOOK_CUR: begin
        // First cycle latches the candidate and raises wall_req; later cycles wait for ack.
        if (!wall_req_q) begin
          if (!sel_stuck) begin
            cand_x_d   = sel_x;
            cand_y_d   = sel_y;
            look_dir_d = sel_dir;
            wall_req_d = 1'b1;
          end
        end else if (wall_ack) begin
          wall_req_d = 1'b0;
        end
        if ((!wall_req_q && sel_stuck) || (wall_req_q && wall_ack && wall_blocked)) begin
          if (state_q == S_LOOK_REQ && dir_cur_q != DIR_NONE) state_d = S_LOOK_CUR;
          else                                                 state_d = S_WAIT_TICK;
        end else if (wall_req_q && wall_ack) begin
          if (state_q == S_LOOK_REQ) dir_cur_d = look_dir_q;
          state_d = S_COMMIT;
        end
      end
      S_COMMIT: begin
        pac_x_d      = cand_x_q;
        pac_y_d      = cand_y_q;
        move_pulse_d = 1'b1;
        state_d      = S_WAIT_TICK;
      end
      S_HALT: begin
        if (ack) begin
          state_d     = S_IDLE;
          pac_x_d     = 10'(X_INI);
          pac_y_d     = 10'(Y_INI);
          dir_cur_d   = DIR_NONE;
          dir_req_d   = DIR_NONE;
          halt_code_d = 2'b00;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Game over pre-empts any lookup or commit in flight.
    if ((win || lose) && state_q != S_IDLE && state_q != S_HALT) begin
      state_d      = S_HALT;
      halt_code_d  = win ? 2'b01 : 2'b10;
      wall_req_d   = 1'b0;
      move_pulse_d = 1'b0;
      pac_x_d      = pac_x_q;
      pac_y_d      = pac_y_q;
      dir_cur_d    = dir_cur_q;
    end
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      pac_x_q      <= 10'(X_INI);
      pac_y_q      <= 10'(Y_INI);
      cand_x_q     <= 10'(X_INI);
      cand_y_q     <= 10'(Y_INI);
      dir_cur_q    <= DIR_NONE;
      dir_req_q    <= DIR_NONE;
      look_dir_q   <= DIR_NONE;
      wall_req_q   <= 1'b0;
      move_pulse_q <= 1'b0;
      halt_code_q  <= 2'b00;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      pac_x_q      <= pac_x_d;
      pac_y_q      <= pac_y_d;
      cand_x_q     <= cand_x_d;
      cand_y_q     <= cand_y_d;
      dir_cur_q    <= dir_cur_d;
      dir_req_q    <= dir_req_d;
      look_dir_q   <= look_dir_d;
      wall_req_q   <= wall_req_d;
      move_pulse_q <= move_pulse_d;
      halt_code_q  <= halt_code_d;
    end
  end

  assign wall_req   = wall_req_q;
  assign wall_x     = cand_x_q;
  assign wall_y     = cand_y_q;
  assign pac_x      = pac_x_q;
  assign pac_y      = pac_y_q;
  assign dir_cur    = dir_cur_q;
  assign move_pulse = move_pulse_q;
  assign halt_code  = halt_code_q;

endmodule

// File: tb/tb_pacman_move_sequencer.sv
// Directed bench for pacman_move_sequencer with TICK_DIV=4 and a maze responder that acks
// half a cycle after each request; blocked only for upward tiles when block_up is set.
module tb_pacman_move_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       start, ack, win, lose;
  logic       btn_l, btn_u, btn_r, btn_d;
  logic       wall_req, wall_ack, wall_blocked;
  logic [9:0] wall_x, wall_y, pac_x, pac_y;
  logic [2:0] dir_cur;
  logic       move_pulse;
  logic [1:0] halt_code;

  int tests_run    = 0;
  int tests_failed = 0;
  bit ack_en       = 1'b1;
  bit block_up     = 1'b0;

  pacman_move_sequencer #(.TICK_DIV(4)) dut (
    .clk(clk), .reset(reset), .start(start), .ack(ack), .win(win), .lose(lose),
    .btn_l(btn_l), .btn_u(btn_u), .btn_r(btn_r), .btn_d(btn_d),
    .wall_req(wall_req), .wall_x(wall_x), .wall_y(wall_y),
    .wall_ack(wall_ack), .wall_blocked(wall_blocked),
    .pac_x(pac_x), .pac_y(pac_y), .dir_cur(dir_cur),
    .move_pulse(move_pulse), .halt_code(halt_code)
  );

  always #5 clk = ~clk;

  initial begin
    wall_ack     = 1'b0;
    wall_blocked = 1'b0;
    forever begin
      @(negedge clk);
      wall_ack     = ack_en && wall_req;
      wall_blocked = block_up && (wall_y < pac_y);
    end
  end

  task automatic check(input string tag, input int got, input int exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_pulse(input string tag, output int n);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!move_pulse && n < 50);
    if (!move_pulse) check({tag, "_timeout"}, int'(move_pulse), 1);
  endtask

  task automatic wait_req(input string tag);
    int n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!wall_req && n < 50);
    if (!wall_req) check({tag, "_timeout"}, int'(wall_req), 1);
  endtask

  task automatic press(input int which);
    case (which)
      1: btn_l = 1'b1;
      2: btn_u = 1'b1;
      3: btn_r = 1'b1;
      default: btn_d = 1'b1;
    endcase
    cycles(1);
    {btn_l, btn_u, btn_r, btn_d} = 4'b0000;
  endtask

  initial begin
    int n, moves;
    bit saw_req, saw_pulse;
    reset = 1'b1;
    {start, ack, win, lose} = 4'b0000;
    {btn_l, btn_u, btn_r, btn_d} = 4'b0000;
    #12;
    check("rst_pac_x", int'(pac_x), 300);
    check("rst_pac_y", int'(pac_y), 300);
    check("rst_dir_cur", int'(dir_cur), 0);
    check("rst_wall_req", int'(wall_req), 0);
    check("rst_move_pulse", int'(move_pulse), 0);
    check("rst_halt_code", int'(halt_code), 0);
    @(negedge clk);
    reset = 1'b0;
    cycles(1);

    // 1: steady rightward motion
    btn_r = 1'b1;
    start = 1'b1;
    wait_pulse("t1_p1", n);
    check("t1_first_latency", n, 8);
    check("t1_p1_x", int'(pac_x), 301);
    check("t1_p1_y", int'(pac_y), 300);
    check("t1_dir_cur", int'(dir_cur), 3);
    wait_pulse("t1_p2", n);
    check("t1_period", n, 7);
    check("t1_p2_x", int'(pac_x), 302);
    btn_r = 1'b0;
    wait_pulse("t1_p3", n);
    check("t1_p3_x", int'(pac_x), 303);

    // 2: blocked upward request falls back to current direction and is retried
    block_up = 1'b1;
    press(2);
    wait_pulse("t2_p1", n);
    check("t2_retry_period", n + 1, 9);
    check("t2_x", int'(pac_x), 304);
    check("t2_y", int'(pac_y), 300);
    check("t2_dir_cur", int'(dir_cur), 3);
    check("t2_dir_req", int'(dut.dir_req_q), 2);
    wait_pulse("t2_p2", n);
    check("t2_retry2_period", n, 9);
    check("t2_x2", int'(pac_x), 305);
    block_up = 1'b0;
    wait_pulse("t2_up", n);
    check("t2_up_period", n, 7);
    check("t2_up_y", int'(pac_y), 299);
    check("t2_up_x", int'(pac_x), 305);
    check("t2_up_dir", int'(dir_cur), 2);

    // 3: run right into the X_MAX clamp
    press(3);
    moves = 0;
    while (pac_x != 10'd663 && moves < 400) begin
      wait_pulse("t3_run", n);
      moves++;
    end
    check("t3_moves", moves, 358);
    check("t3_x_max", int'(pac_x), 663);
    check("t3_dir_cur", int'(dir_cur), 3);
    saw_req = 1'b0;
    saw_pulse = 1'b0;
    repeat (40) begin
      cycles(1);
      saw_req   |= wall_req;
      saw_pulse |= move_pulse;
    end
    check("t3_no_wall_req", int'(saw_req), 0);
    check("t3_no_pulse", int'(saw_pulse), 0);
    check("t3_x_held", int'(pac_x), 663);

    // 4: two buttons together leave the request sticky
    btn_l = 1'b1;
    btn_u = 1'b1;
    cycles(10);
    check("t4_dual_hold", int'(dut.dir_req_q), 3);
    btn_l = 1'b0;
    btn_u = 1'b0;
    press(4);
    check("t4_down_req", int'(dut.dir_req_q), 4);
    wait_pulse("t4_down", n);
    check("t4_down_y", int'(pac_y), 300);
    check("t4_down_dir", int'(dir_cur), 4);

    // 5: lose during an outstanding lookup, then restart
    ack_en = 1'b0;
    wait_req("t5_req");
    lose = 1'b1;
    cycles(1);
    lose = 1'b0;
    check("t5_req_dropped", int'(wall_req), 0);
    check("t5_halt_lost", int'(halt_code), 2);
    check("t5_x_frozen", int'(pac_x), 663);
    check("t5_y_frozen", int'(pac_y), 300);
    cycles(5);
    check("t5_halt_held", int'(halt_code), 2);
    check("t5_no_pulse", int'(move_pulse), 0);
    ack_en = 1'b1;
    start = 1'b0;
    ack = 1'b1;
    cycles(1);
    ack = 1'b0;
    check("t5_ini_x", int'(pac_x), 300);
    check("t5_ini_y", int'(pac_y), 300);
    check("t5_halt_clr", int'(halt_code), 0);
    check("t5_dir_cur_clr", int'(dir_cur), 0);
    check("t5_dir_req_clr", int'(dut.dir_req_q), 0);
    lose = 1'b1;
    cycles(3);
    lose = 1'b0;
    check("t5_idle_ignores_lose", int'(halt_code), 0);
    check("t5_idle_no_req", int'(wall_req), 0);

    // win has priority over lose
    btn_r = 1'b1;
    start = 1'b1;
    wait_pulse("t5_win_move", n);
    btn_r = 1'b0;
    check("t5_win_move_x", int'(pac_x), 301);
    win = 1'b1;
    lose = 1'b1;
    cycles(1);
    {win, lose} = 2'b00;
    check("t5_halt_won", int'(halt_code), 1);
    start = 1'b0;
    ack = 1'b1;
    cycles(1);
    ack = 1'b0;
    check("t5_won_clr", int'(halt_code), 0);
    check("t5_won_ini_x", int'(pac_x), 300);

    // 6: asynchronous reset during a pending request
    btn_l = 1'b1;
    start = 1'b1;
    wait_pulse("t6_move", n);
    btn_l = 1'b0;
    check("t6_moved_x", int'(pac_x), 299);
    ack_en = 1'b0;
    press(2);
    wait_req("t6_req");
    start = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    check("t6_rst_req", int'(wall_req), 0);
    check("t6_rst_x", int'(pac_x), 300);
    check("t6_rst_y", int'(pac_y), 300);
    check("t6_rst_dir", int'(dir_cur), 0);
    @(negedge clk);
    reset = 1'b0;
    ack_en = 1'b1;
    cycles(10);
    check("t6_idle_req", int'(wall_req), 0);
    check("t6_idle_x", int'(pac_x), 300);
    check("t6_idle_dir_req", int'(dut.dir_req_q), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
